// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: captures A/B on En, produces A-B one bit
// per clock LSB first, then publishes Diff/Borrow/Overflow with a Done pulse.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [0:WIDTH-1] A,
    input  logic [0:WIDTH-1] B,
    input  logic             En,
    output logic [0:WIDTH-1] Diff,
    output logic             Borrow,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    logic [0:WIDTH-1] r_a, r_b, r_res;
    logic             r_a_msb, r_b_msb, r_br;
    logic [CW-1:0]    r_cnt;

    // Index WIDTH-1 is the LSB, so the operand registers shift toward it.
    logic             w_a, w_b, w_d, w_br_next, w_last;
    logic [0:WIDTH-1] w_res_next;

    assign w_a        = r_a[WIDTH-1];
    assign w_b        = r_b[WIDTH-1];
    assign w_d        = w_a ^ w_b ^ r_br;
    assign w_br_next  = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
    assign w_res_next = {w_d, r_res[0:WIDTH-2]};
    assign w_last     = (r_cnt == CW'(WIDTH-1));

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            Diff     <= '0;
            Borrow   <= 1'b0;
            Overflow <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (En) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_a_msb <= A[0];
                        r_b_msb <= B[0];
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        Busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a   <= {1'b0, r_a[0:WIDTH-2]};
                    r_b   <= {1'b0, r_b[0:WIDTH-2]};
                    r_res <= w_res_next;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        // w_d is the final MSB of the difference.
                        Diff     <= w_res_next;
                        Borrow   <= w_br_next;
                        Overflow <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results queued at issue,
// popped and compared by a monitor whenever Done is seen.
module tb_serial_subtractor;

    localparam int W = 4;

    logic           Clk = 1'b0, Reset_n = 1'b0, En = 1'b0;
    logic [0:W-1]   A = '0, B = '0;
    logic [0:W-1]   Diff;
    logic           Borrow, Overflow, Busy, Done;

    serial_subtractor #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .A(A), .B(B), .En(En),
        .Diff(Diff), .Borrow(Borrow), .Overflow(Overflow),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [0:W-1] d;
        logic         br;
        logic         ov;
    } exp_t;

    exp_t         q[$];
    int           n_cmp = 0, n_bad = 0;
    bit           mon_on = 0;
    logic [0:W-1] h_d = '0;
    logic         h_br = 1'b0, h_ov = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic reference.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   m, sa, sb, sd;
        m    = 1 << W;
        e.d  = W'((a - b + m) % m);
        e.br = (a < b);
        sa   = (a >= m/2) ? a - m : a;
        sb   = (b >= m/2) ? b - m : b;
        sd   = sa - sb;
        e.ov = (sd < -(m/2)) || (sd > m/2 - 1);
        return e;
    endfunction

    always @(posedge Clk) begin
        if (!Reset_n) begin
            h_d  = '0;
            h_br = 1'b0;
            h_ov = 1'b0;
            q.delete();
        end
    end

    always @(negedge Clk) begin
        exp_t e;
        if (mon_on) begin
            if (Done) begin
                if (q.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("diff", Diff, e.d);
                    chk("borrow", Borrow, e.br);
                    chk("overflow", Overflow, e.ov);
                    chk("busy_at_done", Busy, 0);
                    h_d  = e.d;
                    h_br = e.br;
                    h_ov = e.ov;
                end
            end else begin
                chk("hold_diff", Diff, h_d);
                chk("hold_borrow", Borrow, h_br);
                chk("hold_overflow", Overflow, h_ov);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Returns positioned in the Done cycle (or after the bound expires).
    task automatic wait_done(output int busy_cnt);
        int guard;
        busy_cnt = 0;
        guard    = 0;
        while (Done !== 1'b1 && guard < 20) begin
            if (Busy === 1'b1) busy_cnt++;
            tick();
            guard++;
        end
        if (guard >= 20) chk("done_timeout", 0, 1);
    endtask

    task automatic op(input int a, input int b);
        int bc;
        A  = W'(a);
        B  = W'(b);
        En = 1'b1;
        q.push_back(model(a, b));
        tick();
        En = 1'b0;
        A  = W'($urandom);
        B  = W'($urandom);
        wait_done(bc);
        chk("busy_cycles", bc, W);
    endtask

    initial begin
        int bc;
        tick();
        tick();
        Reset_n = 1'b1;
        mon_on  = 1;
        chk("rst_diff", Diff, 0);
        chk("rst_borrow", Borrow, 0);
        chk("rst_overflow", Overflow, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        repeat (3) tick();
        chk("idle_busy", Busy, 0);

        op(9, 3);
        op(3, 9);
        op(8, 1);
        op(5, 5);
        tick();

        // En during Busy is ignored
        A = 9; B = 3; En = 1'b1;
        q.push_back(model(9, 3));
        tick();
        En = 1'b0;
        tick();
        tick();
        A = 1; B = 1; En = 1'b1;
        tick();
        En = 1'b0;
        chk("busy_during_ignored_en", Busy, 1);
        wait_done(bc);
        op(15, 0);   // accepted in the Done cycle

        // Reset aborts an operation in progress
        tick();
        A = 3; B = 9; En = 1'b1;
        tick();
        En = 1'b0;
        tick();
        tick();
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        chk("abort_diff", Diff, 0);
        chk("abort_borrow", Borrow, 0);
        chk("abort_overflow", Overflow, 0);
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        repeat (8) tick();

        op(9, 3);
        for (int i = 0; i < 40; i++) begin
            op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
        end
        repeat (6) tick();
        if (q.size() != 0) chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
